// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: FSM encoding, queue entry layout
// and default sizing constants.
package branch_resolver_pkg;

    localparam int DEF_ADDRESS_WIDTH = 22;
    localparam int DEF_DEPTH         = 4;
    localparam int DEF_FLUSH_CYCLES  = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] pc;
        logic                         taken;
    } bq_entry_t;

endpackage

// File: rtl/branch_inflight_fifo.sv
// Synchronous FIFO holding predictions that are in flight between fetch and ALU.
// Clear wins over push and pop; a pop on an empty queue is a no-op.
module branch_inflight_fifo
    import branch_resolver_pkg::*;
#(
    parameter type entry_t = bq_entry_t,
    parameter int  DEPTH   = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  entry_t                 wr_data,
    output entry_t                 rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/branch_resolver.sv
// Matches fetch-time predictions against ALU resolutions, drives the predictor
// update port, and raises a timed flush with redirect PC on mispredicts.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int GHR_SIZE      = 8,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_IF_valid,
    input  logic                     i_IF_isbranch,
    input  logic [ADDRESS_WIDTH-1:0] i_IF_pc,
    input  logic                     i_IF_taken,
    output logic                     o_Stall,
    input  logic                     i_ALU_valid,
    input  logic                     i_ALU_isbranch,
    input  logic                     i_ALU_outcome,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
    output logic                     o_BP_isbranch,
    output logic [GHR_SIZE-1:0]      o_BP_pc,
    output logic                     o_BP_outcome,
    output logic                     o_BP_prediction,
    output logic                     o_Flush,
    output logic [ADDRESS_WIDTH-1:0] o_Redirect_pc,
    output logic [CNT_WIDTH-1:0]     o_Branch_count,
    output logic [CNT_WIDTH-1:0]     o_Mispredict_count,
    output logic                     o_Underflow
);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic                     taken;
    } entry_t;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int QC_W = $clog2(DEPTH) + 1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] redirect_target(
        input logic                     outcome,
        input logic [ADDRESS_WIDTH-1:0] target,
        input logic [ADDRESS_WIDTH-1:0] pc
    );
        return outcome ? target : pc + 1'b1;
    endfunction

    logic [0:0]               state;
    logic [FC_W-1:0]          flush_cnt;
    entry_t                   head;
    entry_t                   push_entry;
    logic                     q_full;
    logic                     q_empty;
    logic [QC_W-1:0]          q_count;
    logic                     idle;
    logic                     pop_req_p0;
    logic                     pop_p0;
    logic                     push_p0;
    logic                     mispredict_p0;

    logic                     vld_p1;
    logic [GHR_SIZE-1:0]      bp_pc_p1;
    logic                     bp_outcome_p1;
    logic                     bp_prediction_p1;
    logic [ADDRESS_WIDTH-1:0] redirect_p1;
    logic [CNT_WIDTH-1:0]     branch_cnt;
    logic [CNT_WIDTH-1:0]     mispredict_cnt;
    logic                     underflow;

    // Stage p0: resolve against the queue head (combinational)
    assign idle          = (state == ST_IDLE);
    assign pop_req_p0    = idle & i_ALU_valid & i_ALU_isbranch;
    assign pop_p0        = pop_req_p0 & (q_count != '0);
    assign mispredict_p0 = pop_p0 & (head.taken != i_ALU_outcome);
    // Younger entries and any same-cycle fetch are wrong-path once a mispredict resolves.
    assign push_p0       = idle & i_IF_valid & i_IF_isbranch & ~mispredict_p0;
    assign push_entry    = '{pc: i_IF_pc, taken: i_IF_taken};
    assign o_Stall       = idle & q_full & ~pop_p0;
    assign o_Flush       = (state == ST_FLUSH);

    branch_inflight_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .push    (push_p0),
        .pop     (pop_p0),
        .clear   (mispredict_p0),
        .wr_data (push_entry),
        .rd_data (head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    // Stage p1: registered predictor update, redirect and statistics
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            vld_p1           <= 1'b0;
            bp_pc_p1         <= '0;
            bp_outcome_p1    <= 1'b0;
            bp_prediction_p1 <= 1'b0;
            redirect_p1      <= '0;
            branch_cnt       <= '0;
            mispredict_cnt   <= '0;
            underflow        <= 1'b0;
        end else begin
            vld_p1 <= pop_p0;
            if (pop_p0) begin
                bp_pc_p1         <= head.pc[GHR_SIZE-1:0];
                bp_outcome_p1    <= i_ALU_outcome;
                bp_prediction_p1 <= head.taken;
                branch_cnt       <= sat_inc(branch_cnt);
            end
            if (mispredict_p0) begin
                redirect_p1    <= redirect_target(i_ALU_outcome, i_ALU_target, head.pc);
                mispredict_cnt <= sat_inc(mispredict_cnt);
            end
            if (pop_req_p0 && q_empty) underflow <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (mispredict_p0) begin
                state     <= ST_FLUSH;
                flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            end
        end else begin
            if (flush_cnt == '0) state <= ST_IDLE;
            else                 flush_cnt <= flush_cnt - 1'b1;
        end
    end

    assign o_BP_isbranch      = vld_p1;
    assign o_BP_pc            = bp_pc_p1;
    assign o_BP_outcome       = bp_outcome_p1;
    assign o_BP_prediction    = bp_prediction_p1;
    assign o_Redirect_pc      = redirect_p1;
    assign o_Branch_count     = branch_cnt;
    assign o_Mispredict_count = mispredict_cnt;
    assign o_Underflow        = underflow;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and randomized bench for branch_resolver against a queue-based
// reference model of the resolver's observable behaviour.
module tb_branch_resolver;

    localparam int AW   = 22;
    localparam int GS   = 8;
    localparam int DP   = 4;
    localparam int FC   = 2;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid, if_isbranch, if_taken;
    logic [AW-1:0] if_pc;
    logic          alu_valid, alu_isbranch, alu_outcome;
    logic [AW-1:0] alu_target;
    logic          o_Stall, o_BP_isbranch, o_BP_outcome, o_BP_prediction;
    logic [GS-1:0] o_BP_pc;
    logic          o_Flush, o_Underflow;
    logic [AW-1:0] o_Redirect_pc;
    logic [CW-1:0] o_Branch_count, o_Mispredict_count;

    branch_resolver #(
        .ADDRESS_WIDTH (AW),
        .GHR_SIZE      (GS),
        .DEPTH         (DP),
        .FLUSH_CYCLES  (FC),
        .CNT_WIDTH     (CW)
    ) dut (
        .i_Clk              (clk),
        .i_Reset            (rst),
        .i_IF_valid         (if_valid),
        .i_IF_isbranch      (if_isbranch),
        .i_IF_pc            (if_pc),
        .i_IF_taken         (if_taken),
        .o_Stall            (o_Stall),
        .i_ALU_valid        (alu_valid),
        .i_ALU_isbranch     (alu_isbranch),
        .i_ALU_outcome      (alu_outcome),
        .i_ALU_target       (alu_target),
        .o_BP_isbranch      (o_BP_isbranch),
        .o_BP_pc            (o_BP_pc),
        .o_BP_outcome       (o_BP_outcome),
        .o_BP_prediction    (o_BP_prediction),
        .o_Flush            (o_Flush),
        .o_Redirect_pc      (o_Redirect_pc),
        .o_Branch_count     (o_Branch_count),
        .o_Mispredict_count (o_Mispredict_count),
        .o_Underflow        (o_Underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic          taken;
    } ent_t;

    ent_t          q[$];
    int            m_flush_left;
    logic          m_bp_vld, m_bp_out, m_bp_pred, m_under;
    logic [GS-1:0] m_bp_pc;
    logic [AW-1:0] m_redir;
    int            m_bc, m_mc;
    int            vectors    = 0;
    int            miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flush_left = 0;
        m_bp_vld = 0; m_bp_out = 0; m_bp_pred = 0; m_under = 0;
        m_bp_pc = '0; m_redir = '0; m_bc = 0; m_mc = 0;
    endtask

    function automatic logic exp_stall(input logic av, input logic ab);
        return (m_flush_left == 0) && (q.size() == DP) && !(av && ab);
    endfunction

    task automatic model_edge(input logic iv, input logic ib, input logic [AW-1:0] ipc,
                              input logic it, input logic av, input logic ab,
                              input logic ao, input logic [AW-1:0] at);
        bit   idle;
        bit   mis;
        ent_t h;
        idle = (m_flush_left == 0);
        mis  = 0;
        if (!idle) m_flush_left--;
        m_bp_vld = 0;
        if (idle && av && ab) begin
            if (q.size() == 0) begin
                m_under = 1;
            end else begin
                h = q.pop_front();
                m_bp_vld  = 1;
                m_bp_pc   = h.pc[GS-1:0];
                m_bp_out  = ao;
                m_bp_pred = h.taken;
                if (m_bc < CMAX) m_bc++;
                if (h.taken != ao) begin
                    mis = 1;
                    if (m_mc < CMAX) m_mc++;
                    m_redir = ao ? at : AW'(h.pc + 1);
                    q.delete();
                    m_flush_left = FC;
                end
            end
        end
        if (idle && iv && ib && !mis && q.size() < DP) q.push_back('{pc: ipc, taken: it});
    endtask

    task automatic check_regs();
        chk("bp_isbranch",   o_BP_isbranch,      m_bp_vld);
        chk("bp_pc",         o_BP_pc,            m_bp_pc);
        chk("bp_outcome",    o_BP_outcome,       m_bp_out);
        chk("bp_prediction", o_BP_prediction,    m_bp_pred);
        chk("flush",         o_Flush,            m_flush_left > 0);
        chk("redirect_pc",   o_Redirect_pc,      m_redir);
        chk("branch_count",  o_Branch_count,     m_bc);
        chk("mispred_count", o_Mispredict_count, m_mc);
        chk("underflow",     o_Underflow,        m_under);
    endtask

    task automatic step(input logic iv, input logic ib, input logic [AW-1:0] ipc,
                        input logic it, input logic av, input logic ab,
                        input logic ao, input logic [AW-1:0] at);
        @(negedge clk);
        if_valid = iv; if_isbranch = ib; if_pc = ipc; if_taken = it;
        alu_valid = av; alu_isbranch = ab; alu_outcome = ao; alu_target = at;
        #1;
        chk("stall", o_Stall, exp_stall(av, ab));
        @(posedge clk);
        model_edge(iv, ib, ipc, it, av, ab, ao, at);
        #1;
        check_regs();
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic t);
        step(1, 1, pc, t, 0, 0, 0, '0);
    endtask

    task automatic pop(input logic o, input logic [AW-1:0] tgt);
        step(0, 0, '0, 0, 1, 1, o, tgt);
    endtask

    task automatic idle_cycle();
        step(0, 0, '0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 0; if_isbranch = 0; if_pc = '0; if_taken = 0;
        alu_valid = 0; alu_isbranch = 0; alu_outcome = 0; alu_target = '0;
        model_reset();
        #1;
        check_regs();
        chk("stall_reset", o_Stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Correct prediction
        push(22'h10, 1);
        pop(1, 22'h0);
        idle_cycle();

        // Mispredict not-taken -> taken; same-cycle push and flush-time pushes are dropped
        push(22'h20, 0);
        push(22'h21, 0);
        step(1, 1, 22'h99, 1, 1, 1, 1, 22'h40);
        push(22'h55, 1);
        push(22'h56, 1);
        push(22'h30, 1);
        pop(1, 22'h0);

        // Mispredict taken -> not-taken at the top of the address space
        push(22'h3FFFFF, 1);
        pop(0, 22'h1234);
        idle_cycle();
        idle_cycle();

        // Full queue, stall, push+pop while full, then drain in order
        push(22'h01, 1);
        push(22'h02, 1);
        push(22'h03, 0);
        push(22'h04, 1);
        push(22'h77, 1);
        step(1, 1, 22'h05, 1, 1, 1, 1, 22'h0);
        pop(1, 22'h0);
        pop(0, 22'h0);
        pop(1, 22'h0);
        pop(1, 22'h0);

        // Empty pop: sticky underflow, no update
        pop(1, 22'h0);
        idle_cycle();

        // Asynchronous reset in the middle of a flush
        push(22'h05, 0);
        push(22'h06, 0);
        pop(1, 22'h100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        chk("stall_rst_mid", o_Stall, 1'b0);
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst = 1'b0;
        pop(1, 22'h0);

        // Randomized traffic; long enough for the counters to saturate
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), AW'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), AW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer-side counterpart of the branch predictor. Records each prediction issued at fetch in an in-flight queue and matches it against the ALU-stage resolution.
- Drives the predictor's update interface (outcome, pc, isbranch, prediction).
- On misprediction, raises a pipeline flush with a redirect PC.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- ADDRESS_WIDTH, 22, PC width (word address).
- GHR_SIZE, 8, predictor index width; o_BP_pc = low GHR_SIZE bits of PC.
- DEPTH, 4, in-flight queue entries; power of two, ≥2.
- FLUSH_CYCLES, 2, cycles o_Flush is held per mispredict; ≥1.
- CNT_WIDTH, 16, statistics counter width.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_IF_valid  in  1  fetch slot valid.
- i_IF_isbranch  in  1  fetched instruction is a branch.
- i_IF_pc  in  ADDRESS_WIDTH  fetch PC.
- i_IF_taken  in  1  predictor o_taken for this fetch.
- o_Stall  out  1  queue full; fetch must hold the branch.
- i_ALU_valid  in  1  ALU slot valid.
- i_ALU_isbranch  in  1  ALU instruction is a branch.
- i_ALU_outcome  in  1  resolved direction (1 = taken).
- i_ALU_target  in  ADDRESS_WIDTH  resolved taken target.
- o_BP_isbranch  out  1  predictor update strobe.
- o_BP_pc  out  GHR_SIZE  PC index of the resolved branch.
- o_BP_outcome  out  1  resolved direction.
- o_BP_prediction  out  1  direction that was predicted.
- o_Flush  out  1  squash IF/ID.
- o_Redirect_pc  out  ADDRESS_WIDTH  correct next PC; valid on the first o_Flush cycle.
- o_Branch_count  out  CNT_WIDTH  branches resolved.
- o_Mispredict_count  out  CNT_WIDTH  mispredictions.
- o_Underflow  out  1  sticky: ALU resolved a branch while the queue was empty.

Behaviour:
- Reset (async, i_Reset=1): all outputs 0, queue empty, pointers 0, FSM = IDLE, counters 0.
- Queue: FIFO of {pc, taken}, DEPTH entries, wrapping read/write pointers, occupancy count 0..DEPTH.
- Push when i_IF_valid & i_IF_isbranch & state==IDLE & (not full, or pop in the same cycle).
- o_Stall = full & no pop this cycle. Combinational from count and ALU inputs.
- Pop when i_ALU_valid & i_ALU_isbranch.
  - Head supplies pc/prediction.
  - Pop on an empty queue: no pointer change, o_Underflow set (cleared only by reset), no BP update, no flush.
- Update latency: registered, 1 cycle. In cycle N+1 after a pop in cycle N:
  - o_BP_isbranch = 1 for exactly one cycle.
  - o_BP_pc = head.pc[GHR_SIZE-1:0], o_BP_outcome = i_ALU_outcome, o_BP_prediction = head.taken.
- Mispredict when head.taken != i_ALU_outcome:
  - o_Redirect_pc = outcome ? i_ALU_target : head.pc + 1 (mod 2^ADDRESS_WIDTH).
  - Wrap-around: PC all-ones + 1 = 0.
- FSM:
  - IDLE --(pop & mispredict)--> FLUSH, load flush counter with FLUSH_CYCLES-1.
  - FLUSH: o_Flush=1. Decrement each cycle; at 0 return to IDLE.
  - o_Flush rises in cycle N+1, together with o_BP_isbranch.
- On mispredict in cycle N, queue cleared at edge N (all younger entries are wrong-path). A push in the same cycle is dropped.
- In FLUSH: pushes ignored, o_Stall=0. ALU pops are ignored, and must not occur because ALU is squashed. Counters untouched.
- Correct prediction: no flush, o_Redirect_pc holds its last value.
- Counters: o_Branch_count +1 per valid pop, o_Mispredict_count +1 per mispredict. Both saturate at all-ones; no wrap.
- Simultaneous push + pop with the queue full: permitted; count unchanged; pointers both advance.
- Reset asserted mid-flush: immediate return to IDLE, o_Flush=0.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE, FLUSH.
  - Queue entry struct {pc, taken}.
  - Default constants for DEPTH and FLUSH_CYCLES.
- One sub-module: branch_inflight_fifo. Parameterised synchronous FIFO with push/pop/clear, full/empty and count. Clear has priority over push.

Test Plan:
- Reset mid-operation: push 2 branches, start flush, assert i_Reset → outputs 0, queue empty, counters 0 immediately.
- Correct prediction: push pc=0x10 taken=1; ALU outcome=1 → next cycle o_BP_isbranch=1, o_BP_pc=0x10, o_BP_prediction=1, o_Flush=0, o_Branch_count=1.
- Mispredict not-taken→taken: push pc=0x20 taken=0 and pc=0x21; ALU outcome=1, target=0x40 →
  - o_Flush high 2 cycles; o_Redirect_pc=0x40.
  - Queue empty; o_Mispredict_count=1.
  - Push during flush ignored.
- Mispredict taken→not-taken at pc=0x3FFFFF → o_Redirect_pc=0x000000 (wrap).
- Full queue: push 4 branches → o_Stall=1. Then push + pop in the same cycle → o_Stall=0 that cycle, count stays 4, FIFO order preserved over 4 further pops.
- Empty pop: ALU branch with an empty queue → o_Underflow=1 sticky, no BP update, counters unchanged.
